// File: rtl/mem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_ctrl
// Description : MEM-stage load/store sequencer. Turns the load or store held
//               in the MEM pipeline register into a single data-bus
//               transaction (req/gnt, then rvalid) and stalls the MEM stage
//               while the access is in flight. Covers byte-lane steering,
//               load sign/zero extension, misalignment detection, bus errors,
//               a request/response timeout and flush-drain of an outstanding
//               response.
// Ports       : clk, rst_n                 clock / async active-low reset
//               req_*_i                    MEM-stage instruction fields
//               flush_i, wb_ready_i        pipeline control
//               lsu_run_o                  MEM stage may advance
//               ld_data_o, bus_err_o       load result / error (valid in DONE)
//               ld_misalign_o/st_misalign_o misaligned access flags (IDLE)
//               dbus_*                     data-bus master interface
// Revision    : 1.0  initial release
// ============================================================================
module mem_lsu_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  input  logic            req_ld_i,
  input  logic            req_st_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic            flush_i,
  input  logic            wb_ready_i,
  output logic            lsu_run_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            ld_misalign_o,
  output logic            st_misalign_o,
  output logic            bus_err_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_be_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_err_i
);

  localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [1:0]      r_lane;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic            r_is_load;
  logic [XLEN-1:0] r_ld_data;
  logic            r_bus_err;

  logic            w_mem_op;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_misalign;
  logic            w_start;
  logic            w_timeout;
  logic            w_drop_eff;
  logic            w_rsp_done;
  logic            w_to_done;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_lane_data;
  logic [XLEN-1:0] w_ld_ext;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_mem_op   = req_valid_i & (req_ld_i | req_st_i);
  assign w_is_half  = (req_size_i == 2'b01);
  assign w_is_word  = req_size_i[1];            // reserved 2'b11 behaves as word
  assign w_misalign = (w_is_half & req_addr_i[0]) |
                      (w_is_word & (req_addr_i[1:0] != 2'b00));
  assign w_start    = (r_state == ST_IDLE) & w_mem_op & ~w_misalign & ~flush_i;

  // Counter holds (cycles spent in REQ/WAIT - 1), so this fires in the last
  // allowed cycle and the transition lands right after it.
  assign w_timeout  = (r_cnt == C_TO_LAST);

  // A flush seen in the same cycle as the response or timeout already counts
  // as a drop.
  assign w_drop_eff = r_drop | flush_i;

  // Store lane steering
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << req_addr_i[1:0];
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata_i;
      end
    endcase
  end

  // Load extraction from the registered byte lane
  assign w_lane_data = dbus_rdata_i >> {r_lane, 3'b000};

  always_comb begin
    w_ld_ext = w_lane_data;
    case (r_size)
      2'b00:   w_ld_ext = {{(XLEN-8){~r_unsigned & w_lane_data[7]}}, w_lane_data[7:0]};
      2'b01:   w_ld_ext = {{(XLEN-16){~r_unsigned & w_lane_data[15]}}, w_lane_data[15:0]};
      default: w_ld_ext = w_lane_data;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_rsp_done  = 1'b0;
    w_to_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_drop_nxt = 1'b0;
        if (w_start) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (flush_i && !dbus_gnt_i) begin
          // Request withdrawn before the bus accepted it.
          w_state_nxt = ST_IDLE;
          w_drop_nxt  = 1'b0;
        end else if (w_timeout) begin
          // flush_i here implies gnt: a response may follow but is unwanted.
          w_drop_nxt = 1'b0;
          if (flush_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
            w_to_done   = 1'b1;
          end
        end else if (dbus_gnt_i) begin
          w_state_nxt = ST_WAIT;
          w_drop_nxt  = flush_i;
        end
      end
      ST_WAIT: begin
        if (dbus_rvalid_i) begin
          w_drop_nxt = 1'b0;
          if (w_drop_eff) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
            w_rsp_done  = 1'b1;
          end
        end else if (w_timeout) begin
          w_drop_nxt = 1'b0;
          if (w_drop_eff) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
            w_to_done   = 1'b1;
          end
        end else begin
          w_drop_nxt = w_drop_eff;
        end
      end
      ST_DONE: begin
        if (wb_ready_i || flush_i) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    dbus_req_o    = 1'b0;
    lsu_run_o     = 1'b0;
    ld_misalign_o = 1'b0;
    st_misalign_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        lsu_run_o     = ~w_mem_op | w_misalign | flush_i;
        ld_misalign_o = w_mem_op & req_ld_i & w_misalign;
        st_misalign_o = w_mem_op & req_st_i & w_misalign;
      end
      ST_REQ:  dbus_req_o = 1'b1;
      ST_DONE: lsu_run_o  = 1'b1;
      default: lsu_run_o  = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Timeout counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Transaction and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_lane     <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_is_load  <= 1'b0;
      r_ld_data  <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr     <= {req_addr_i[XLEN-1:2], 2'b00};
        r_we       <= req_st_i;
        r_be       <= w_be;
        r_wdata    <= w_wdata;
        r_lane     <= req_addr_i[1:0];
        r_size     <= req_size_i;
        r_unsigned <= req_unsigned_i;
        r_is_load  <= req_ld_i;
        r_bus_err  <= 1'b0;
      end
      if (w_rsp_done) begin
        r_bus_err <= dbus_err_i;
        if (r_is_load) r_ld_data <= w_ld_ext;
      end
      if (w_to_done) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_wdata_o = r_wdata;
  assign dbus_be_o    = r_be;
  assign ld_data_o    = r_ld_data;
  assign bus_err_o    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu_ctrl
// Description : Directed self-checking bench for mem_lsu_ctrl. Inputs change
//               and outputs are checked around the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ld, req_st, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        flush, wb_ready;
  logic        lsu_run, ld_misalign, st_misalign, bus_err;
  logic [31:0] ld_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid, dbus_err;
  logic [31:0] dbus_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_lsu_ctrl #(.XLEN(32), .TIMEOUT_CYC(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ld_i       (req_ld),
    .req_st_i       (req_st),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .flush_i        (flush),
    .wb_ready_i     (wb_ready),
    .lsu_run_o      (lsu_run),
    .ld_data_o      (ld_data),
    .ld_misalign_o  (ld_misalign),
    .st_misalign_o  (st_misalign),
    .bus_err_o      (bus_err),
    .dbus_req_o     (dbus_req),
    .dbus_we_o      (dbus_we),
    .dbus_addr_o    (dbus_addr),
    .dbus_wdata_o   (dbus_wdata),
    .dbus_be_o      (dbus_be),
    .dbus_gnt_i     (dbus_gnt),
    .dbus_rvalid_i  (dbus_rvalid),
    .dbus_rdata_i   (dbus_rdata),
    .dbus_err_i     (dbus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 0; req_ld = 0; req_st = 0; req_unsigned = 0;
    req_size = 2'b00; req_addr = '0; req_wdata = '0; flush = 0; wb_ready = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0; dbus_rdata = '0;

    // ---------------- reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_be", dbus_be, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_run", lsu_run, 1);
    rst_n = 1'b1;

    // ---------------- LB 0x103, rdata 0x80FF_FF7F
    @(negedge clk);
    req_valid = 1; req_ld = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h103;
    #1; chk("lb_idle_run", lsu_run, 0);
    @(negedge clk); #1;
    chk("lb_req", dbus_req, 1);
    chk("lb_addr", dbus_addr, 32'h100);
    chk("lb_be", dbus_be, 4'b1000);
    chk("lb_we", dbus_we, 0);
    dbus_gnt = 1;
    @(negedge clk);
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h80FF_FF7F;
    #1; chk("lb_wait_req", dbus_req, 0); chk("lb_wait_run", lsu_run, 0);
    @(negedge clk);
    dbus_rvalid = 0;
    #1; chk("lb_data", ld_data, 32'hFFFF_FF80); chk("lb_done_run", lsu_run, 1);
    wb_ready = 1;

    // ---------------- LBU same address
    @(negedge clk); wb_ready = 0; req_unsigned = 1;
    @(negedge clk); dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0; dbus_rvalid = 1;
    @(negedge clk); dbus_rvalid = 0;
    #1; chk("lbu_data", ld_data, 32'h0000_0080);
    wb_ready = 1;

    // ---------------- SH 0x102, gnt two cycles late
    @(negedge clk);
    wb_ready = 0; req_ld = 0; req_st = 1; req_size = 2'b01; req_unsigned = 0;
    req_addr = 32'h102; req_wdata = 32'h1234_ABCD;
    #1; chk("sh_misalign", st_misalign, 0); chk("sh_idle_run", lsu_run, 0);
    @(negedge clk); #1;
    chk("sh_req", dbus_req, 1);
    chk("sh_be", dbus_be, 4'b1100);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    chk("sh_we", dbus_we, 1);
    chk("sh_run_req", lsu_run, 0);
    @(negedge clk); #1; chk("sh_req_hold", dbus_req, 1);
    @(negedge clk); dbus_gnt = 1; #1; chk("sh_run_req2", lsu_run, 0);
    @(negedge clk); dbus_gnt = 0; dbus_rvalid = 1; #1; chk("sh_run_wait", lsu_run, 0);
    @(negedge clk); dbus_rvalid = 0;
    #1; chk("sh_run_done", lsu_run, 1); chk("sh_ld_keep", ld_data, 32'h0000_0080);
    chk("sh_err", bus_err, 0);
    wb_ready = 1;

    // ---------------- SB 0x101 with bus error response
    @(negedge clk); wb_ready = 0; req_size = 2'b00; req_addr = 32'h101; req_wdata = 32'h0000_005A;
    @(negedge clk); #1;
    chk("sb_be", dbus_be, 4'b0010);
    chk("sb_wdata", dbus_wdata, 32'h5A5A_5A5A);
    dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0; dbus_rvalid = 1; dbus_err = 1;
    @(negedge clk); dbus_rvalid = 0; dbus_err = 0;
    #1; chk("sb_bus_err", bus_err, 1);
    wb_ready = 1;

    // ---------------- misaligned LW 0x101 / SW 0x102
    @(negedge clk);
    wb_ready = 0; req_ld = 1; req_st = 0; req_size = 2'b10; req_addr = 32'h101;
    #1;
    chk("lw_mis_ld", ld_misalign, 1);
    chk("lw_mis_st", st_misalign, 0);
    chk("lw_mis_run", lsu_run, 1);
    chk("lw_mis_req", dbus_req, 0);
    @(negedge clk); #1; chk("lw_mis_req2", dbus_req, 0);
    req_ld = 0; req_st = 1; req_addr = 32'h102;
    #1; chk("sw_mis_st", st_misalign, 1); chk("sw_mis_run", lsu_run, 1);
    @(negedge clk); #1; chk("sw_mis_req", dbus_req, 0);

    // ---------------- LH 0x102 flushed in WAIT, response 3 cycles later
    req_ld = 1; req_st = 0; req_size = 2'b01; req_addr = 32'h102;
    @(negedge clk); dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0; flush = 1; #1; chk("fl_run_wait", lsu_run, 0);
    @(negedge clk); flush = 0; req_valid = 0; #1; chk("fl_run_drain1", lsu_run, 0);
    @(negedge clk); #1; chk("fl_run_drain2", lsu_run, 0);
    @(negedge clk); dbus_rvalid = 1; dbus_rdata = 32'h5555_AAAA;
    #1; chk("fl_run_drain3", lsu_run, 0);
    @(negedge clk); dbus_rvalid = 0;
    #1; chk("fl_idle_run", lsu_run, 1); chk("fl_ld_keep", ld_data, 32'h0000_0080);
    chk("fl_req", dbus_req, 0);

    // ---------------- LH 0x102 signed
    @(negedge clk); req_valid = 1; req_ld = 1; req_size = 2'b01; req_addr = 32'h102;
    @(negedge clk); dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h8001_7FFF;
    @(negedge clk); dbus_rvalid = 0;
    #1; chk("lh_data", ld_data, 32'hFFFF_8001);
    wb_ready = 1;

    // ---------------- flush in REQ without gnt withdraws the request
    @(negedge clk); wb_ready = 0; req_size = 2'b10; req_addr = 32'h200;
    @(negedge clk); flush = 1; #1; chk("frq_req", dbus_req, 1);
    @(negedge clk); flush = 0; req_valid = 0;
    #1; chk("frq_withdrawn", dbus_req, 0); chk("frq_run", lsu_run, 1);

    // ---------------- timeout: gnt, never rvalid
    @(negedge clk); req_valid = 1;
    @(negedge clk); dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0;
    repeat (14) @(negedge clk);
    #1; chk("to_run16", lsu_run, 0); chk("to_err16", bus_err, 0);
    @(negedge clk);
    #1; chk("to_err", bus_err, 1); chk("to_run", lsu_run, 1);
    chk("to_ld_keep", ld_data, 32'hFFFF_8001);
    req_valid = 0; wb_ready = 1;

    // ---------------- reset while in WAIT
    @(negedge clk); wb_ready = 0; req_valid = 1; req_addr = 32'h300;
    @(negedge clk); dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0; req_valid = 0;
    @(negedge clk); rst_n = 0;
    #1;
    chk("rw_req", dbus_req, 0);
    chk("rw_addr", dbus_addr, 0);
    chk("rw_be", dbus_be, 0);
    chk("rw_ld", ld_data, 0);
    chk("rw_run", lsu_run, 1);
    @(negedge clk); rst_n = 1;
    @(negedge clk); dbus_rvalid = 1; dbus_rdata = 32'hDEAD_BEEF;
    #1; chk("rw_stray_run", lsu_run, 1); chk("rw_stray_req", dbus_req, 0);
    @(negedge clk); dbus_rvalid = 0;
    #1; chk("rw_ld_keep", ld_data, 0); chk("rw_err", bus_err, 0);

    // ---------------- normal LW 0x400 after reset
    @(negedge clk); req_valid = 1; req_ld = 1; req_size = 2'b10; req_addr = 32'h400;
    @(negedge clk); #1;
    chk("lw_addr", dbus_addr, 32'h400); chk("lw_be", dbus_be, 4'b1111);
    dbus_gnt = 1;
    @(negedge clk); dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h1234_5678;
    @(negedge clk); dbus_rvalid = 0;
    #1; chk("lw_data", ld_data, 32'h1234_5678);
    wb_ready = 1; req_valid = 0;
    @(negedge clk); wb_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
